// File: rtl/frame_fifo_write.sv
// Frame write DMA stage: drains the video-in write FIFO into memory as fixed-size bursts.
// Optional FRAME_WRITE_TAIL_FLUSH_EN: final short burst so memory receives exactly write_len words.
module frame_fifo_write #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BUSRT_BITS    = 10,
    parameter int FIFO_DEPTH    = 512,
    parameter int BURST_SIZE    = 128
) (
    input  logic                  rst,
    input  logic                  mem_clk,
    output logic                  wr_burst_req,
    output logic [BUSRT_BITS-1:0] wr_burst_len,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    output logic                  fifo_rdreq,
    input  logic                  write_req,
    output logic                  write_req_ack,
    output logic                  write_finish,
    input  logic [ADDR_BITS-1:0]  write_addr_0,
    input  logic [ADDR_BITS-1:0]  write_addr_1,
    input  logic [ADDR_BITS-1:0]  write_addr_2,
    input  logic [ADDR_BITS-1:0]  write_addr_3,
    input  logic [1:0]            write_addr_index,
    input  logic [ADDR_BITS-1:0]  write_len,
    output logic                  fifo_aclr,
    input  logic [15:0]           rdusedw
);

    localparam int EW = ADDR_BITS + 17;
    localparam logic [BUSRT_BITS-1:0] BURST_LEN = BUSRT_BITS'(BURST_SIZE);
    localparam logic [EW-1:0]         BURST_EXT = EW'(BURST_SIZE);

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_ACK             = 3'd1,
        S_CHECK_FIFO      = 3'd2,
        S_WRITE_BURST     = 3'd3,
        S_WRITE_BURST_END = 3'd4,
        S_END             = 3'd5
    } state_t;

    state_t               state;
    logic                 req_d0, req_d1, req_d2;
    logic [ADDR_BITS-1:0] len_d0, len_d1;
    logic [1:0]           index_d0, index_d1;
    logic [ADDR_BITS-1:0] write_cnt;
    logic [ADDR_BITS-1:0] len_latch;
    logic [ADDR_BITS-1:0] base_sel;
    logic [ADDR_BITS-1:0] burst_len_ext;
    logic [EW-1:0]        used_ext;

    assign used_ext      = {{(EW-16){1'b0}}, rdusedw};
    assign burst_len_ext = {{(ADDR_BITS-BUSRT_BITS){1'b0}}, wr_burst_len};
    assign fifo_rdreq    = (state == S_WRITE_BURST) && wr_burst_data_req;
    assign write_finish  = (state == S_END);

`ifdef FRAME_WRITE_TAIL_FLUSH_EN
    logic [ADDR_BITS-1:0] rem;
    logic [EW-1:0]        rem_ext;
    assign rem     = len_latch - write_cnt;
    assign rem_ext = {{(EW-ADDR_BITS){1'b0}}, rem};
`endif

    always_comb begin
        base_sel = write_addr_0;
        case (index_d1)
            2'd0:    base_sel = write_addr_0;
            2'd1:    base_sel = write_addr_1;
            2'd2:    base_sel = write_addr_2;
            default: base_sel = write_addr_3;
        endcase
    end

    // Request needs three flops; the quasi-static len/index settle within two.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            req_d0   <= 1'b0;
            req_d1   <= 1'b0;
            req_d2   <= 1'b0;
            len_d0   <= '0;
            len_d1   <= '0;
            index_d0 <= '0;
            index_d1 <= '0;
        end else begin
            req_d0   <= write_req;
            req_d1   <= req_d0;
            req_d2   <= req_d1;
            len_d0   <= write_len;
            len_d1   <= len_d0;
            index_d0 <= write_addr_index;
            index_d1 <= index_d0;
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            write_req_ack <= 1'b0;
            fifo_aclr     <= 1'b0;
            write_cnt     <= '0;
            len_latch     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    write_req_ack <= 1'b0;
                    if (req_d2) state <= S_ACK;
                end
                S_ACK: begin
                    write_cnt <= '0;
                    if (req_d2) begin
                        write_req_ack <= 1'b1;
                        fifo_aclr     <= 1'b1;
                        wr_burst_addr <= base_sel;
                        len_latch     <= len_d1;
                    end else begin
                        write_req_ack <= 1'b0;
                        fifo_aclr     <= 1'b0;
                        state         <= S_CHECK_FIFO;
                    end
                end
                S_CHECK_FIFO: begin
                    if (req_d2) begin
                        state <= S_ACK;
                    end else if (write_cnt >= len_latch) begin
                        state <= S_END;
`ifdef FRAME_WRITE_TAIL_FLUSH_EN
                    end else if (rem_ext < BURST_EXT) begin
                        // Short tail: wait only for the words that remain.
                        if (used_ext >= rem_ext) begin
                            wr_burst_len <= rem[BUSRT_BITS-1:0];
                            wr_burst_req <= 1'b1;
                            state        <= S_WRITE_BURST;
                        end
`endif
                    end else if (used_ext >= BURST_EXT) begin
                        wr_burst_len <= BURST_LEN;
                        wr_burst_req <= 1'b1;
                        state        <= S_WRITE_BURST;
                    end
                end
                S_WRITE_BURST: begin
                    if (wr_burst_data_req) wr_burst_req <= 1'b0;
                    if (wr_burst_finish) begin
                        write_cnt     <= write_cnt + burst_len_ext;
                        wr_burst_addr <= wr_burst_addr + burst_len_ext;
                        state         <= S_WRITE_BURST_END;
                    end
                end
                S_WRITE_BURST_END: begin
                    if (req_d2)                      state <= S_ACK;
                    else if (write_cnt < len_latch)  state <= S_CHECK_FIFO;
                    else                             state <= S_END;
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Directed bench for frame_fifo_write: a bench-side memory controller serves each burst.
// Define FRAME_WRITE_TAIL_FLUSH_EN to also exercise the short tail burst.
module tb_frame_fifo_write;

    logic        rst;
    logic        mem_clk;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [22:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic        fifo_rdreq;
    logic        write_req;
    logic        write_req_ack;
    logic        write_finish;
    logic [22:0] write_addr_0, write_addr_1, write_addr_2, write_addr_3;
    logic [1:0]  write_addr_index;
    logic [22:0] write_len;
    logic        fifo_aclr;
    logic [15:0] rdusedw;

    int n_assert = 0;
    int n_fail   = 0;
    int finish_pulses = 0;
    int burst_reqs    = 0;
    logic req_prev = 1'b0;

    frame_fifo_write dut (
        .rst(rst), .mem_clk(mem_clk),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
        .fifo_rdreq(fifo_rdreq), .write_req(write_req), .write_req_ack(write_req_ack),
        .write_finish(write_finish),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
        .write_addr_index(write_addr_index), .write_len(write_len),
        .fifo_aclr(fifo_aclr), .rdusedw(rdusedw)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // Event counters sampled on the falling edge, away from DUT updates.
    always @(negedge mem_clk) begin
        if (write_finish) finish_pulses <= finish_pulses + 1;
        if (wr_burst_req && !req_prev) burst_reqs <= burst_reqs + 1;
        req_prev <= wr_burst_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Waits for the acknowledge, checks the latched base, then drops the request.
    task automatic wait_ack(input string tag, input logic [22:0] exp_base);
        int n = 0;
        while (write_req_ack !== 1'b1 && n < 100) begin @(negedge mem_clk); n++; end
        check({tag, "_ack"}, 32'(write_req_ack), 32'd1);
        check({tag, "_aclr"}, 32'(fifo_aclr), 32'd1);
        check({tag, "_base"}, 32'(wr_burst_addr), 32'(exp_base));
        write_req = 1'b0;
        n = 0;
        while (write_req_ack !== 1'b0 && n < 100) begin @(negedge mem_clk); n++; end
        check({tag, "_ackdrop"}, 32'(write_req_ack), 32'd0);
        check({tag, "_aclrdrop"}, 32'(fifo_aclr), 32'd0);
    endtask

    task automatic start_frame(input string tag, input logic [1:0] idx, input logic [22:0] len,
                               input logic [22:0] exp_base);
        write_addr_index = idx;
        write_len        = len;
        write_req        = 1'b1;
        wait_ack(tag, exp_base);
    endtask

    // Memory controller model: take the request, pull len words, pulse finish.
    task automatic serve(input string tag, input logic [22:0] exp_addr, input logic [9:0] exp_len,
                         input bit raise_req);
        int n = 0;
        while (wr_burst_req !== 1'b1 && n < 200) begin @(negedge mem_clk); n++; end
        check({tag, "_req"}, 32'(wr_burst_req), 32'd1);
        check({tag, "_addr"}, 32'(wr_burst_addr), 32'(exp_addr));
        check({tag, "_len"}, 32'(wr_burst_len), 32'(exp_len));
        wr_burst_data_req = 1'b1;
        @(negedge mem_clk);
        check({tag, "_rdreq"}, 32'(fifo_rdreq), 32'd1);
        check({tag, "_reqdrop"}, 32'(wr_burst_req), 32'd0);
        if (raise_req) write_req = 1'b1;
        repeat (int'(exp_len) - 1) @(negedge mem_clk);
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        check({tag, "_noack"}, 32'(write_req_ack), 32'd0);
        check({tag, "_rdreq_off"}, 32'(fifo_rdreq), 32'd0);
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while (write_finish !== 1'b1 && n < 100) begin @(negedge mem_clk); n++; end
        check({tag, "_fin"}, 32'(write_finish), 32'd1);
        @(negedge mem_clk);
        check({tag, "_finlow"}, 32'(write_finish), 32'd0);
    endtask

    initial begin
        int f0, b0;
        rst = 1'b1;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        write_req         = 1'b0;
        write_addr_0 = 23'h4000;
        write_addr_1 = 23'h2000;
        write_addr_2 = 23'h1000;
        write_addr_3 = 23'h3000;
        write_addr_index = 2'd0;
        write_len = 23'd0;
        rdusedw   = 16'd0;
        repeat (3) @(negedge mem_clk);
        check("rst_req", 32'(wr_burst_req), 32'd0);
        check("rst_len", 32'(wr_burst_len), 32'd0);
        check("rst_addr", 32'(wr_burst_addr), 32'd0);
        check("rst_ack", 32'(write_req_ack), 32'd0);
        check("rst_fin", 32'(write_finish), 32'd0);
        check("rst_aclr", 32'(fifo_aclr), 32'd0);
        check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge mem_clk);

        // 1: four full bursts from write_addr_2.
        f0 = finish_pulses;
        rdusedw = 16'd512;
        start_frame("t1", 2'd2, 23'd512, 23'h1000);
        serve("t1b0", 23'h1000, 10'd128, 1'b0);
        serve("t1b1", 23'h1080, 10'd128, 1'b0);
        serve("t1b2", 23'h1100, 10'd128, 1'b0);
        serve("t1b3", 23'h1180, 10'd128, 1'b0);
        wait_finish("t1");
        repeat (3) @(negedge mem_clk);
        check("t1_pulses", 32'(finish_pulses - f0), 32'd1);
        check("t1_endaddr", 32'(wr_burst_addr), 32'h1200);

        // 2: burst only once 128 words are available.
        rdusedw = 16'd127;
        start_frame("t2", 2'd1, 23'd128, 23'h2000);
        b0 = burst_reqs;
        repeat (20) @(negedge mem_clk);
        check("t2_wait127", 32'(burst_reqs - b0), 32'd0);
        rdusedw = 16'd128;
        @(negedge mem_clk);
        check("t2_req128", 32'(wr_burst_req), 32'd1);
        check("t2_len128", 32'(wr_burst_len), 32'd128);
        serve("t2b0", 23'h2000, 10'd128, 1'b0);
        wait_finish("t2");

        // 3: abort while waiting for FIFO data after one burst.
        f0 = finish_pulses;
        rdusedw = 16'd512;
        start_frame("t3", 2'd1, 23'd512, 23'h2000);
        serve("t3b0", 23'h2000, 10'd128, 1'b0);
        rdusedw = 16'd0;
        b0 = burst_reqs;
        repeat (5) @(negedge mem_clk);
        check("t3_stall", 32'(burst_reqs - b0), 32'd0);
        start_frame("t3r", 2'd3, 23'd128, 23'h3000);
        rdusedw = 16'd512;
        serve("t3rb0", 23'h3000, 10'd128, 1'b0);
        wait_finish("t3r");
        check("t3_pulses", 32'(finish_pulses - f0), 32'd1);

        // 4: request during a burst waits for the burst to finish.
        f0 = finish_pulses;
        start_frame("t4", 2'd0, 23'd256, 23'h4000);
        write_addr_0 = 23'h5000;
        write_len    = 23'd128;
        serve("t4b0", 23'h4000, 10'd128, 1'b1);
        wait_ack("t4r", 23'h5000);
        serve("t4rb0", 23'h5000, 10'd128, 1'b0);
        wait_finish("t4r");
        check("t4_pulses", 32'(finish_pulses - f0), 32'd1);

        // 5: zero-length frame finishes without a burst.
        b0 = burst_reqs;
        start_frame("t5", 2'd2, 23'd0, 23'h1000);
        wait_finish("t5");
        check("t5_noburst", 32'(burst_reqs - b0), 32'd0);

`ifdef FRAME_WRITE_TAIL_FLUSH_EN
        // 6: 300 words -> 128, 128, then a 44-word tail.
        write_addr_3 = 23'h6000;
        rdusedw = 16'd512;
        start_frame("t6", 2'd3, 23'd300, 23'h6000);
        serve("t6b0", 23'h6000, 10'd128, 1'b0);
        serve("t6b1", 23'h6080, 10'd128, 1'b0);
        rdusedw = 16'd43;
        b0 = burst_reqs;
        repeat (10) @(negedge mem_clk);
        check("t6_wait43", 32'(burst_reqs - b0), 32'd0);
        rdusedw = 16'd44;
        @(negedge mem_clk);
        check("t6_req44", 32'(wr_burst_req), 32'd1);
        serve("t6b2", 23'h6100, 10'd44, 1'b0);
        wait_finish("t6");
        check("t6_endaddr", 32'(wr_burst_addr), 32'h612C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
